// File: rtl/adder_seq.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, rippling the carry
// between cycles through a register, with valid/ready handshakes on both sides.
module adder_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [31:0]      lsb;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CHUNK-1:0] a_s;
  logic [CHUNK-1:0] b_s;
  logic [CHUNK:0]   add;
  logic             c_msb;

  // Slice datapath for the current chunk index
  always_comb begin
    lsb   = 32'(idx_q) * CHUNK;
    a_sh  = a_q >> lsb;
    b_sh  = b_q >> lsb;
    a_s   = a_sh[CHUNK-1:0];
    b_s   = b_sh[CHUNK-1:0];
    add   = {1'b0, a_s} + {1'b0, b_s} + (CHUNK+1)'(carry_q);
    // Carry into the slice MSB recovered from its sum bit and operand bits
    c_msb = add[CHUNK-1] ^ a_s[CHUNK-1] ^ b_s[CHUNK-1];
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : c_in;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d   = (sum_q & ~(SLICE_MASK << lsb)) | (WIDTH'(add[CHUNK-1:0]) << lsb);
        carry_d = add[CHUNK];
        if (idx_q == IDX_LAST) begin
          c_out_d = add[CHUNK];
          ovf_d   = c_msb ^ add[CHUNK];
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_seq.sv
// Bench for adder_seq: directed vectors at 8/4, handshake corner cases, and a
// randomized sweep at WIDTH=32 for CHUNK 1, 4 and 32 against an arithmetic model.
module tb_adder_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  out_ready;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  c_out;
  logic [3:0]  ovf;
  logic [31:0] a_v, b_v;
  logic        c_in_v, sub_v;
  logic [7:0]  sum8;
  logic [31:0] sum_c1, sum_c4, sum_c32;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_seq #(.WIDTH(8), .CHUNK(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_v[7:0]), .b(b_v[7:0]), .c_in(c_in_v), .sub(sub_v),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum8),
    .c_out(c_out[0]), .ovf(ovf[0]));

  adder_seq #(.WIDTH(32), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_v), .b(b_v), .c_in(c_in_v), .sub(sub_v),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum_c1),
    .c_out(c_out[1]), .ovf(ovf[1]));

  adder_seq #(.WIDTH(32), .CHUNK(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_v), .b(b_v), .c_in(c_in_v), .sub(sub_v),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum_c4),
    .c_out(c_out[2]), .ovf(ovf[2]));

  adder_seq #(.WIDTH(32), .CHUNK(32)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .a(a_v), .b(b_v), .c_in(c_in_v), .sub(sub_v),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .sum(sum_c32),
    .c_out(c_out[3]), .ovf(ovf[3]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       c;
    logic       v;
  } vec_t;

  function automatic logic [31:0] sum_of(int d);
    case (d)
      0:       return {24'h0, sum8};
      1:       return sum_c1;
      2:       return sum_c4;
      default: return sum_c32;
    endcase
  endfunction

  function automatic int nchunk_of(int d);
    case (d)
      0:       return 2;
      1:       return 32;
      2:       return 8;
      default: return 1;
    endcase
  endfunction

  // Reference: integer arithmetic on the operand values, signed range check for ovf
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub,
                                output logic [31:0] s, output logic c, output logic v);
    longint m  = longint'(1) << w;
    longint ua = longint'(a) % m;
    longint ub = longint'(b) % m;
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    longint r  = sub ? ua - ub : ua + ub + longint'(cin);
    longint sr = sub ? sa - sb : sa + sb + longint'(cin);
    s = 32'(((r % m) + m) % m);
    c = sub ? (ua >= ub) : (r >= m);
    v = (sr < -(m / 2)) || (sr >= m / 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on DUT d with result and latency checks
  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] es,
                        input logic ec, input logic ev, input int hold);
    int n = 0;
    while (!in_ready[d] && n < 200) begin
      tick();
      n++;
    end
    chk("in_ready_before_accept", 32'(in_ready[d]), 32'd1);
    a_v = a; b_v = b; c_in_v = cin; sub_v = sub;
    in_valid[d] = 1'b1;
    tick();
    in_valid[d] = 1'b0;
    a_v = $urandom; b_v = $urandom; c_in_v = 1'($urandom); sub_v = 1'($urandom);
    n = 0;
    while (!out_valid[d] && n < 200) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(nchunk_of(d)));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid[d]), 32'd1);
    end
    chk("sum", sum_of(d), es);
    chk("c_out", 32'(c_out[d]), 32'(ec));
    chk("ovf", 32'(ovf[d]), 32'(ev));
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    chk("idle_after_handshake", {30'd0, in_ready[d], out_valid[d]}, 32'b10);
  endtask

  initial begin
    vec_t vecs[5];
    logic [31:0] es;
    logic ec, ev;

    vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h10, c: 1'b0, v: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b1, sub: 1'b0, sum: 8'h01, c: 1'b1, v: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h80, c: 1'b0, v: 1'b1};
    vecs[3] = '{a: 8'h05, b: 8'h07, cin: 1'b1, sub: 1'b1, sum: 8'hFE, c: 1'b0, v: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, cin: 1'b1, sub: 1'b1, sum: 8'h7F, c: 1'b1, v: 1'b1};

    rst = 1'b1; in_valid = '0; out_ready = '0;
    a_v = '0; b_v = '0; c_in_v = 1'b0; sub_v = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'hF);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_sum", sum_of(0) | sum_of(1) | sum_of(2) | sum_of(3), 32'h0);
    chk("reset_flags", {28'd0, c_out | ovf}, 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++)
      run_op(0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin, vecs[i].sub,
             32'(vecs[i].sum), vecs[i].c, vecs[i].v, 0);

    // Backpressure with new requests ignored, then chaining on the release edge
    a_v = 32'h0F; b_v = 32'h01; c_in_v = 1'b0; sub_v = 1'b0;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (2) tick();
    chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_v = $urandom; b_v = $urandom;
      tick();
      chk("bp_sum_stable", sum_of(0), 32'h10);
      chk("bp_state", {30'd0, in_ready[0], out_valid[0]}, 32'b01);
    end
    a_v = 32'h01; b_v = 32'h02;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("chain_not_taken", {30'd0, in_ready[0], out_valid[0]}, 32'b10);
    tick();
    in_valid[0] = 1'b0;
    chk("chain_taken", 32'(in_ready[0]), 32'd0);
    repeat (2) tick();
    chk("chain_sum", sum_of(0), 32'h03);
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;

    // Reset during BUSY discards the operation
    a_v = 32'h33; b_v = 32'h44; c_in_v = 1'b0; sub_v = 1'b0;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_state", {30'd0, in_ready[0], out_valid[0]}, 32'b10);
    chk("abort_sum", sum_of(0), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_valid", 32'(out_valid[0]), 32'd0);
    end
    run_op(0, 32'h12, 32'h34, 1'b0, 1'b0, 32'h46, 1'b0, 1'b0, 0);

    // Randomized sweep at WIDTH=32
    for (int i = 0; i < 1000; i++) begin
      int d;
      logic [31:0] ra, rb;
      logic rc, rs;
      d  = 1 + (i % 3);
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      rs = 1'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'h8000_0000;
        2: ra = 32'h7FFF_FFFF;
        3: rb = ra;
        default: ;
      endcase
      model(32, ra, rb, rc, rs, es, ec, ev);
      run_op(d, ra, rb, rc, rs, es, ec, ev, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_seq.md
# adder_seq

Parametrised multi-cycle adder/subtractor. It adds `CHUNK` bits per clock and ripples the carry between cycles through a register. Operands are accepted and results returned over valid/ready handshakes. It succeeds the fixed 4-bit combinational adder as the ALU-side arithmetic building block for the core, trading latency for area at large `WIDTH`.

## Interface
- `WIDTH`, 32: operand and result width in bits. Must be a multiple of `CHUNK`.
- `CHUNK`, 4: bits added per cycle, 1 ≤ `CHUNK` ≤ `WIDTH`. `NCHUNK` = `WIDTH`/`CHUNK`.
- `clk`  in  1  rising-edge clock. Single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `c_in`  in  1  carry in. Used only when `sub`=0.
- `sub`  in  1  0: sum = a + b + c_in. 1: sum = a − b, computed as a + ~b + 1.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  result, modulo 2^WIDTH.
- `c_out`  out  1  carry out of bit WIDTH−1. For `sub`, 1 means no borrow.
- `ovf`  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. `in_ready` = (state==IDLE) and `out_valid` = (state==DONE), both decoded from registered state.
- **IDLE**: on `in_valid && in_ready`:
  - latch `a`;
  - latch `b`, or `~b` when `sub`=1;
  - set carry register = `sub` ? 1 : `c_in`;
  - set chunk index = 0;
  - go to BUSY.
- **BUSY**: each cycle:
  - compute {c, s} = A[idx] + B[idx] + carry on the CHUNK-bit slice;
  - write s into `sum` slice idx;
  - update carry to c.
  - When idx == NCHUNK−1, also latch `c_out` = c and `ovf` = (carry into bit WIDTH−1) XOR c, then go to DONE. Otherwise idx increments.
- **DONE**:
  - `sum`, `c_out` and `ovf` are held stable until `out_valid && out_ready`, then the FSM returns to IDLE.
  - Outputs keep their last value after leaving DONE, but are only meaningful while `out_valid`=1.
- `a`, `b`, `c_in` and `sub` are sampled only on the accept edge. Changes while in BUSY or DONE are ignored.
- `in_valid` outside IDLE is ignored; there is no queueing. `out_ready` outside DONE is ignored.
- Arithmetic wraps modulo 2^WIDTH; the carry is reported only via `c_out`.
- `NCHUNK`=1 is legal and gives a single BUSY cycle.

## Timing
- **Reset** (async assert, immediate effect): state=IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `c_out`=0, `ovf`=0, idx=0, carry=0.
- **Latency**: if operands are accepted at edge k, then `out_valid` rises after edge k+NCHUNK. The first output edge at which `out_valid` is seen high is k+NCHUNK+1.
- **Throughput**: with `out_ready` held at 1, one result every NCHUNK+2 cycles (accept, NCHUNK BUSY cycles, DONE).
- **Backpressure**: DONE holds indefinitely, and `in_ready` stays 0 for the duration.
- **Reset mid-BUSY or mid-DONE**: the operation is discarded and `out_valid` never rises for it. The next accept after reset release must be correct.
- **Chaining**: `in_valid` asserted in the same cycle as the DONE→IDLE handshake is not accepted until the following cycle, when `in_ready`=1.

## Test plan
All scenarios use WIDTH=8, CHUNK=4 unless stated.
- **Add, inter-chunk carry**: a=0x0F, b=0x01, c_in=0, sub=0 -> sum=0x10, c_out=0, ovf=0. `out_valid` high exactly 2 edges after accept.
- **Add, carry-in and wrap**: a=0xFF, b=0x01, c_in=1 -> sum=0x01, c_out=1, ovf=0.
- **Add, signed overflow**: a=0x7F, b=0x01, c_in=0 -> sum=0x80, c_out=0, ovf=1.
- **Subtract** (with c_in=1, which must be ignored):
  - a=0x05, b=0x07, sub=1 -> sum=0xFE, c_out=0, ovf=0;
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, c_out=1, ovf=1.
- **Backpressure**: hold `out_ready`=0 for 10 cycles in DONE while driving new `in_valid` with changing a/b -> `sum` stays stable, `in_ready`=0, nothing accepted. Raise `out_ready` -> IDLE next cycle.
- **Reset abort and random sweep**:
  - assert `rst` during the BUSY of an operation -> `out_valid` stays 0 and `in_ready`=1;
  - then run 1000 random operations at WIDTH=32 with CHUNK ∈ {1, 4, 32} against the reference model a ± b + c_in -> all of sum, c_out and ovf match.
